// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one single-port sprite ROM (1-cycle read latency)
// between the pixel-draw path (port 0) and the collision-check path (port 1).
// Round-robin grant per cycle, two-stage response pipeline, held read data.
// Optional build macro: ADDR_RANGE_CHECK_EN (out-of-range reads return 0 with rerrN).
module sprite_rom_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 900
) (
   input  logic                  clka,
   input  logic                  rsta,
   input  logic                  req0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic                  rerr0,
   input  logic                  req1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  rerr1,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data
);

   // ptr_q = 0 gives port 0 priority on contention, 1 gives port 1.
   logic                  ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  gnt0_s, gnt1_s, grant_s;
   logic [ADDR_WIDTH-1:0] gaddr_s, eff_addr_s;
   logic                  oor_s;
   // Stage 1: read issued last cycle, ROM data is valid this cycle.
   logic                  s1_vld_q, s1_tag_q, s1_err_q;
   // Stage 2: response registers.
   logic                  rvalid0_q, rvalid1_q, rerr0_q, rerr1_q;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

   // Round-robin grant; nothing is granted while reset is asserted.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (rsta) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (req0 && req1) begin
         if (ptr_q) begin
            gnt1_s = 1'b1;
         end else begin
            gnt0_s = 1'b1;
         end
      end else if (req0) begin
         gnt0_s = 1'b1;
      end else if (req1) begin
         gnt1_s = 1'b1;
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   assign grant_s = gnt0_s | gnt1_s;
   assign gaddr_s = gnt1_s ? addr1 : addr0;

`ifdef ADDR_RANGE_CHECK_EN
   // Out-of-range reads still take their slot but address word 0 of the ROM.
   assign oor_s      = ({{(32-ADDR_WIDTH){1'b0}}, gaddr_s} >= 32'(DEPTH));
   assign eff_addr_s = oor_s ? {ADDR_WIDTH{1'b0}} : gaddr_s;
`else
   assign oor_s      = 1'b0;
   assign eff_addr_s = gaddr_s;
`endif

   // The ROM address only moves on a grant; otherwise it holds the last one.
   assign rom_addr = grant_s ? eff_addr_s : addr_q;

   // Next-state for pointer and held address.
   always_comb begin
      ptr_d  = ptr_q;
      addr_d = addr_q;
      if (grant_s) begin
         ptr_d  = ~gnt1_s;
         addr_d = eff_addr_s;
      end else begin
         ptr_d  = ptr_q;
         addr_d = addr_q;
      end
   end

   // Pointer and held ROM address registers.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         ptr_q  <= 1'b0;
         addr_q <= {ADDR_WIDTH{1'b0}};
      end else begin
         ptr_q  <= ptr_d;
         addr_q <= addr_d;
      end
   end

   // Stage 1: remember which port issued this cycle's read.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         s1_vld_q <= 1'b0;
         s1_tag_q <= 1'b0;
         s1_err_q <= 1'b0;
      end else begin
         s1_vld_q <= grant_s;
         s1_tag_q <= gnt1_s;
         s1_err_q <= oor_s;
      end
   end

   // Stage 2: capture ROM data for the issuing port and pulse its valid.
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rerr0_q   <= 1'b0;
         rerr1_q   <= 1'b0;
         rdata0_q  <= {DATA_WIDTH{1'b0}};
         rdata1_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         rvalid0_q <= s1_vld_q & ~s1_tag_q;
         rvalid1_q <= s1_vld_q & s1_tag_q;
         if (s1_vld_q && !s1_tag_q) begin
            rdata0_q <= s1_err_q ? {DATA_WIDTH{1'b0}} : rom_data;
            rerr0_q  <= s1_err_q;
         end
         if (s1_vld_q && s1_tag_q) begin
            rdata1_q <= s1_err_q ? {DATA_WIDTH{1'b0}} : rom_data;
            rerr1_q  <= s1_err_q;
         end
      end
   end

   assign gnt0    = gnt0_s;
   assign gnt1    = gnt1_s;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
`ifdef ADDR_RANGE_CHECK_EN
   assign rerr0   = rerr0_q;
   assign rerr1   = rerr1_q;
`else
   assign rerr0   = 1'b0;
   assign rerr1   = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed, table-driven bench for sprite_rom_arbiter with a behavioural
// 1-cycle-latency ROM: word 5 = 0xF800, every other word a = 0x1000 + a.
module tb_sprite_rom_arbiter;

   logic        clka = 1'b0;
   logic        rsta;
   logic        req0, req1;
   logic [9:0]  addr0, addr1;
   logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
   logic [15:0] rdata0, rdata1;
   logic [9:0]  rom_addr;
   logic [15:0] rom_data = 16'h0000;

   int total  = 0;
   int passed = 0;

   sprite_rom_arbiter dut (
      .clka(clka), .rsta(rsta),
      .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .rerr0(rerr0),
      .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .rerr1(rerr1),
      .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 clka = ~clka;

   function automatic logic [15:0] rom_word(input logic [9:0] a);
      return (a == 10'd5) ? 16'hF800 : (16'h1000 + {6'h00, a});
   endfunction

   // ROM model: registered read, data valid the cycle after the address.
   always @(posedge clka) rom_data <= rom_word(rom_addr);

   typedef struct {
      logic rst; logic r0; logic [9:0] a0; logic r1; logic [9:0] a1;
      logic g0; logic g1; logic [9:0] ra; logic v0; logic v1;
      logic [15:0] d0; logic [15:0] d1; logic e0;
   } vec_t;

   function automatic vec_t mk(input logic rst, r0, input logic [9:0] a0, input logic r1,
                               input logic [9:0] a1, input logic g0, g1, input logic [9:0] ra,
                               input logic v0, v1, input logic [15:0] d0, d1, input logic e0);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
      v.g0 = g0; v.g1 = g1; v.ra = ra; v.v0 = v0; v.v1 = v1;
      v.d0 = d0; v.d1 = d1; v.e0 = e0;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end else begin
         passed++;
      end
   endtask

   // Drive one cycle's inputs just after the edge, check just before the midpoint.
   task automatic apply(input vec_t v, input int idx);
      @(posedge clka);
      #1;
      rsta = v.rst; req0 = v.r0; addr0 = v.a0; req1 = v.r1; addr1 = v.a1;
      #2;
      chk("gnt0",     idx, {31'd0, gnt0},    {31'd0, v.g0});
      chk("gnt1",     idx, {31'd0, gnt1},    {31'd0, v.g1});
      chk("rom_addr", idx, {22'd0, rom_addr}, {22'd0, v.ra});
      chk("rvalid0",  idx, {31'd0, rvalid0}, {31'd0, v.v0});
      chk("rvalid1",  idx, {31'd0, rvalid1}, {31'd0, v.v1});
      chk("rdata0",   idx, {16'd0, rdata0},  {16'd0, v.d0});
      chk("rdata1",   idx, {16'd0, rdata1},  {16'd0, v.d1});
      chk("rerr0",    idx, {31'd0, rerr0},   {31'd0, v.e0});
      chk("rerr1",    idx, {31'd0, rerr1},   32'd0);
   endtask

`ifdef ADDR_RANGE_CHECK_EN
   localparam logic [9:0]  RA900 = 10'd0;
   localparam logic [15:0] D900  = 16'h0000;
   localparam logic        E900  = 1'b1;
`else
   localparam logic [9:0]  RA900 = 10'd900;
   localparam logic [15:0] D900  = 16'h1384;
   localparam logic        E900  = 1'b0;
`endif

   vec_t tbl[36];

   initial begin
      rsta = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 10'd0; addr1 = 10'd0;
      //             rst r0 a0   r1 a1     g0 g1 ra     v0 v1 d0        d1        e0
      // Port 0 alone, word 5
      tbl[0]  = mk(1, 0, 0,    0, 0,     0, 0, 0,     0, 0, 16'h0000, 16'h0000, 0);
      tbl[1]  = mk(0, 1, 5,    0, 0,     1, 0, 5,     0, 0, 16'h0000, 16'h0000, 0);
      tbl[2]  = mk(0, 0, 0,    0, 0,     0, 0, 5,     0, 0, 16'h0000, 16'h0000, 0);
      tbl[3]  = mk(0, 0, 0,    0, 0,     0, 0, 5,     1, 0, 16'hF800, 16'h0000, 0);
      tbl[4]  = mk(0, 0, 0,    0, 0,     0, 0, 5,     0, 0, 16'hF800, 16'h0000, 0);
      // Reset, then continuous contention: strict alternation
      tbl[5]  = mk(1, 0, 0,    0, 0,     0, 0, 0,     0, 0, 16'h0000, 16'h0000, 0);
      tbl[6]  = mk(0, 1, 1,    1, 2,     1, 0, 1,     0, 0, 16'h0000, 16'h0000, 0);
      tbl[7]  = mk(0, 1, 1,    1, 2,     0, 1, 2,     0, 0, 16'h0000, 16'h0000, 0);
      tbl[8]  = mk(0, 1, 1,    1, 2,     1, 0, 1,     1, 0, 16'h1001, 16'h0000, 0);
      tbl[9]  = mk(0, 1, 1,    1, 2,     0, 1, 2,     0, 1, 16'h1001, 16'h1002, 0);
      tbl[10] = mk(0, 1, 1,    1, 2,     1, 0, 1,     1, 0, 16'h1001, 16'h1002, 0);
      tbl[11] = mk(0, 0, 0,    0, 0,     0, 0, 1,     0, 1, 16'h1001, 16'h1002, 0);
      tbl[12] = mk(0, 0, 0,    0, 0,     0, 0, 1,     1, 0, 16'h1001, 16'h1002, 0);
      // Pointer memory: port 1 alone, 3 idle, then both -> port 0 first
      tbl[13] = mk(0, 0, 0,    1, 7,     0, 1, 7,     0, 0, 16'h1001, 16'h1002, 0);
      tbl[14] = mk(0, 0, 0,    0, 0,     0, 0, 7,     0, 0, 16'h1001, 16'h1002, 0);
      tbl[15] = mk(0, 0, 0,    0, 0,     0, 0, 7,     0, 1, 16'h1001, 16'h1007, 0);
      tbl[16] = mk(0, 0, 0,    0, 0,     0, 0, 7,     0, 0, 16'h1001, 16'h1007, 0);
      tbl[17] = mk(0, 1, 3,    1, 4,     1, 0, 3,     0, 0, 16'h1001, 16'h1007, 0);
      tbl[18] = mk(0, 1, 3,    1, 4,     0, 1, 4,     0, 0, 16'h1001, 16'h1007, 0);
      tbl[19] = mk(0, 0, 0,    0, 0,     0, 0, 4,     1, 0, 16'h1003, 16'h1007, 0);
      tbl[20] = mk(0, 0, 0,    0, 0,     0, 0, 4,     0, 1, 16'h1003, 16'h1004, 0);
      // Back-to-back port 0, words 10..13
      tbl[21] = mk(0, 1, 10,   0, 0,     1, 0, 10,    0, 0, 16'h1003, 16'h1004, 0);
      tbl[22] = mk(0, 1, 11,   0, 0,     1, 0, 11,    0, 0, 16'h1003, 16'h1004, 0);
      tbl[23] = mk(0, 1, 12,   0, 0,     1, 0, 12,    1, 0, 16'h100A, 16'h1004, 0);
      tbl[24] = mk(0, 1, 13,   0, 0,     1, 0, 13,    1, 0, 16'h100B, 16'h1004, 0);
      tbl[25] = mk(0, 0, 0,    0, 0,     0, 0, 13,    1, 0, 16'h100C, 16'h1004, 0);
      tbl[26] = mk(0, 0, 0,    0, 0,     0, 0, 13,    1, 0, 16'h100D, 16'h1004, 0);
      tbl[27] = mk(0, 0, 0,    0, 0,     0, 0, 13,    0, 0, 16'h100D, 16'h1004, 0);
      // Reset mid-flight: port 1 read discarded
      tbl[28] = mk(0, 0, 0,    1, 9,     0, 1, 9,     0, 0, 16'h100D, 16'h1004, 0);
      tbl[29] = mk(1, 0, 0,    0, 0,     0, 0, 0,     0, 0, 16'h0000, 16'h0000, 0);
      tbl[30] = mk(0, 0, 0,    0, 0,     0, 0, 0,     0, 0, 16'h0000, 16'h0000, 0);
      tbl[31] = mk(0, 0, 0,    0, 0,     0, 0, 0,     0, 0, 16'h0000, 16'h0000, 0);
      // Port 1 drops its request before being granted: no side effects
      tbl[32] = mk(0, 1, 20,   1, 21,    1, 0, 20,    0, 0, 16'h0000, 16'h0000, 0);
      tbl[33] = mk(0, 0, 0,    0, 0,     0, 0, 20,    0, 0, 16'h0000, 16'h0000, 0);
      tbl[34] = mk(0, 0, 0,    0, 0,     0, 0, 20,    1, 0, 16'h1014, 16'h0000, 0);
      tbl[35] = mk(0, 0, 0,    0, 0,     0, 0, 20,    0, 0, 16'h1014, 16'h0000, 0);

      repeat (2) @(posedge clka);
      for (int i = 0; i < 36; i++) begin
         apply(tbl[i], i);
      end

      // Range boundary: 900 is out of range, 899 is the last valid word.
      apply(mk(0, 1, 900, 0, 0, 1, 0, RA900,  0, 0, 16'h1014, 16'h0000, 0),    100);
      apply(mk(0, 1, 899, 0, 0, 1, 0, 10'd899, 0, 0, 16'h1014, 16'h0000, 0),   101);
      apply(mk(0, 0, 0,   0, 0, 0, 0, 10'd899, 1, 0, D900,     16'h0000, E900), 102);
      apply(mk(0, 0, 0,   0, 0, 0, 0, 10'd899, 1, 0, 16'h1383, 16'h0000, 0),    103);
      apply(mk(0, 0, 0,   0, 0, 0, 0, 10'd899, 0, 0, 16'h1383, 16'h0000, 0),    104);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
